// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI message types, byte-class constants and helpers.
package midi_pkg;

    typedef enum logic [2:0] {
        NOTE_OFF, NOTE_ON, POLY_AT, CC, PROG, CH_AT, PITCH
    } msg_type_e;

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} parse_state_e;

    localparam int          STATUS_BIT  = 7;
    localparam logic [7:0]  SYSEX_START = 8'hF0;
    localparam logic [7:0]  SYSEX_END   = 8'hF7;
    localparam logic [7:0]  RT_BASE     = 8'hF8;

    typedef struct packed {
        msg_type_e   mtype;
        logic [3:0]  ch;
        logic [6:0]  d1;
        logic [6:0]  d2;
    } midi_msg_t;

    function automatic logic [1:0] nbytes(msg_type_e t);
        return (t == PROG || t == CH_AT) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/midi_msg_fifo.sv
// midi_msg_fifo: first-word fall-through message queue with simultaneous push/pop.
module midi_msg_fifo
    import midi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  midi_msg_t data_i,
    input  logic      pop_i,
    output midi_msg_t data_o,
    output logic      vld_o,
    output logic      full_o
);

    localparam int AW = $clog2(DEPTH);

    midi_msg_t         mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [AW:0]       cnt_q;
    logic              push_ok, pop_ok;

    assign vld_o   = cnt_q != '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign data_o  = mem_q[rd_ptr_q];
    // A push into a full queue is still taken when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && vld_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_q + AW'(push_ok);
            rd_ptr_q <= rd_ptr_q + AW'(pop_ok);
            cnt_q    <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/midi_msg_parser.sv
// midi_msg_parser: MIDI channel-voice decoder with running status, real-time
// pass-through, channel filter and output message queue.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter logic [15:0] CH_MASK     = 16'hFFFF,
    parameter bit          VEL0_IS_OFF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_vld,
    output logic       msg_vld,
    input  logic       msg_rdy,
    output logic [2:0] msg_type,
    output logic [3:0] msg_ch,
    output logic [6:0] msg_d1,
    output logic [6:0] msg_d2,
    output logic       rt_vld,
    output logic [2:0] rt_code,
    output logic       overflow
);

    parse_state_e state_q, state_d;
    msg_type_e    run_type_q, run_type_d;
    logic [3:0]   run_ch_q, run_ch_d;
    logic [6:0]   d1_q, d1_d;
    logic         rt_vld_q, overflow_q;
    logic [2:0]   rt_code_q;
    logic         is_rt, is_ch, done, push, pop, full;
    midi_msg_t    msg, head;

    assign is_rt = din >= RT_BASE;
    assign is_ch = din[STATUS_BIT] && din[7:4] != 4'hF;
    assign pop   = msg_vld && msg_rdy;
    assign push  = done && CH_MASK[msg.ch];

    always_comb begin
        state_d    = state_q;
        run_type_d = run_type_q;
        run_ch_d   = run_ch_q;
        d1_d       = d1_q;
        done       = 1'b0;
        msg        = '{run_type_q, run_ch_q, d1_q, din[6:0]};
        if (din_vld && !is_rt) begin
            if (is_ch) begin
                state_d    = WAIT_D1;
                run_type_d = msg_type_e'(din[6:4]);
                run_ch_d   = din[3:0];
            end else if (din[STATUS_BIT]) begin
                // SysEx and System Common both kill running status.
                state_d    = din == SYSEX_START ? SYSEX : IDLE;
                run_type_d = NOTE_OFF;
                run_ch_d   = '0;
            end else if (state_q == WAIT_D1 && nbytes(run_type_q) == 2'd1) begin
                done   = 1'b1;
                msg.d1 = din[6:0];
                msg.d2 = '0;
            end else if (state_q == WAIT_D1) begin
                d1_d    = din[6:0];
                state_d = WAIT_D2;
            end else if (state_q == WAIT_D2) begin
                done    = 1'b1;
                state_d = WAIT_D1;
            end
        end
        if (VEL0_IS_OFF && msg.mtype == NOTE_ON && msg.d2 == '0) msg.mtype = NOTE_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            run_type_q <= NOTE_OFF;
            run_ch_q   <= '0;
            d1_q       <= '0;
            rt_vld_q   <= 1'b0;
            rt_code_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_type_q <= run_type_d;
            run_ch_q   <= run_ch_d;
            d1_q       <= d1_d;
            rt_vld_q   <= din_vld && is_rt;
            rt_code_q  <= din_vld && is_rt ? din[2:0] : rt_code_q;
            overflow_q <= overflow_q || (push && full && !pop);
        end
    end

    midi_msg_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .data_i (msg),
        .pop_i  (pop),
        .data_o (head),
        .vld_o  (msg_vld),
        .full_o (full)
    );

    assign msg_type = head.mtype;
    assign msg_ch   = head.ch;
    assign msg_d1   = head.d1;
    assign msg_d2   = head.d2;
    assign rt_vld   = rt_vld_q;
    assign rt_code  = rt_code_q;
    assign overflow = overflow_q;

endmodule
